// File: rtl/stage_waveform_generator_if.sv
`default_nettype none
// ============================================================================
//  Module      : stage_waveform_generator_if
//  Description : Sample bus between phase accumulation, the waveform stage and
//                the envelope/mix stage. Carries the phase in, the sine sample
//                out, and the voice/operator and algorithm sidebands that ride
//                alongside each sample.
//                  slave  : the waveform stage (consumes i_*, drives o_*)
//                  master : the surrounding logic (drives i_*, consumes o_*)
//  Ports       : i_Valid, i_ModulatedPhase[15:0] (signed), i_VoiceOperator,
//                i_AlgorithmWord, o_Valid, o_Waveform[15:0] (signed),
//                o_VoiceOperator, o_AlgorithmWord
//  Revision    : 1.0  initial release
// ============================================================================
interface stage_waveform_generator_if #(
    parameter int VOICE_OP_BITS  = 8,
    parameter int ALGORITHM_BITS = 16
);
    typedef logic [VOICE_OP_BITS-1:0]  VoiceOperatorID_t;
    typedef logic [ALGORITHM_BITS-1:0] AlgorithmWord_t;

    logic               i_Valid;
    logic signed [15:0] i_ModulatedPhase;
    VoiceOperatorID_t   i_VoiceOperator;
    AlgorithmWord_t     i_AlgorithmWord;

    logic               o_Valid;
    logic signed [15:0] o_Waveform;
    VoiceOperatorID_t   o_VoiceOperator;
    AlgorithmWord_t     o_AlgorithmWord;

    modport slave (
        input  i_Valid, i_ModulatedPhase, i_VoiceOperator, i_AlgorithmWord,
        output o_Valid, o_Waveform, o_VoiceOperator, o_AlgorithmWord
    );

    modport master (
        output i_Valid, i_ModulatedPhase, i_VoiceOperator, i_AlgorithmWord,
        input  o_Valid, o_Waveform, o_VoiceOperator, o_AlgorithmWord
    );
endinterface
`default_nettype wire

// File: rtl/stage_waveform_generator.sv
`default_nettype none
// ============================================================================
//  Module      : stage_waveform_generator
//  Description : Turns the modulated phase into a signed sine sample using a
//                quarter-wave table with quadrant mirroring. Three-stage
//                pipeline (address, ROM read, sign), one sample per clock, no
//                back-pressure. Voice/operator tag and algorithm word travel
//                with the sample.
//  Ports       : i_Clock  - system clock, rising edge
//                i_Reset  - asynchronous active-high reset
//                bus      - stage_waveform_generator_if.slave (phase in,
//                           sample out, sidebands, valid flags)
//  Revision    : 1.0  initial release
// ============================================================================
module stage_waveform_generator #(
    parameter int LUT_ADDR_BITS  = 10,
    parameter int VOICE_OP_BITS  = 8,
    parameter int ALGORITHM_BITS = 16
) (
    input  logic                             i_Clock,
    input  logic                             i_Reset,
    stage_waveform_generator_if.slave        bus
);
    localparam int  c_LUT_DEPTH = 1 << LUT_ADDR_BITS;
    // Phase bits below the table index are dropped (no interpolation).
    localparam int  c_DROP_BITS = 14 - LUT_ADDR_BITS;
    localparam real c_HALF_PI   = 1.5707963267948966;

    // Quarter-wave entry k = round(32767*sin(pi/2*(k+0.5)/depth)). The table
    // is built at elaboration from this formula, so no image file is needed.
    // The half-step offset makes the ~index mirror exact and keeps every
    // entry non-zero.
    function automatic logic [14:0] sine_entry(input int k);
        real x;
        real term;
        real sum;
        x    = c_HALF_PI * (real'(k) + 0.5) / real'(c_LUT_DEPTH);
        term = x;
        sum  = x;
        for (int n = 1; n < 16; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return 15'($rtoi(32767.0 * sum + 0.5));
    endfunction

    logic [14:0] w_lut [c_LUT_DEPTH];

    for (genvar k = 0; k < c_LUT_DEPTH; k++) begin : g_lut
        localparam logic [14:0] c_ENTRY = sine_entry(k);
        assign w_lut[k] = c_ENTRY;
    end

    // Phase split
    logic [1:0]               w_quadrant;
    logic [LUT_ADDR_BITS-1:0] w_index;
    logic                     w_unused_low_phase;

    assign w_quadrant         = bus.i_ModulatedPhase[15:14];
    assign w_index            = bus.i_ModulatedPhase[13:c_DROP_BITS];
    assign w_unused_low_phase = ^bus.i_ModulatedPhase[c_DROP_BITS-1:0];

    // Stage 1: table address
    logic [LUT_ADDR_BITS-1:0]  r_addr_s1;
    logic                      r_neg_s1;
    logic                      r_valid_s1;
    logic [VOICE_OP_BITS-1:0]  r_vop_s1;
    logic [ALGORITHM_BITS-1:0] r_algo_s1;

    // Stage 2: magnitude from ROM
    logic [14:0]               r_mag_s2;
    logic                      r_neg_s2;
    logic                      r_valid_s2;
    logic [VOICE_OP_BITS-1:0]  r_vop_s2;
    logic [ALGORITHM_BITS-1:0] r_algo_s2;

    // Stage 3: signed sample
    logic [15:0]               r_wave_s3;
    logic                      r_valid_s3;
    logic [VOICE_OP_BITS-1:0]  r_vop_s3;
    logic [ALGORITHM_BITS-1:0] r_algo_s3;

    logic [15:0] w_mag_ext;
    logic [15:0] w_wave;

    // Magnitude never exceeds 32767, so the two's-complement negation can
    // not wrap and -32768 is unreachable.
    assign w_mag_ext = {1'b0, r_mag_s2};
    assign w_wave    = r_neg_s2 ? (16'd0 - w_mag_ext) : w_mag_ext;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_addr_s1  <= '0;
            r_neg_s1   <= 1'b0;
            r_valid_s1 <= 1'b0;
            r_vop_s1   <= '0;
            r_algo_s1  <= '0;
            r_mag_s2   <= '0;
            r_neg_s2   <= 1'b0;
            r_valid_s2 <= 1'b0;
            r_vop_s2   <= '0;
            r_algo_s2  <= '0;
            r_wave_s3  <= '0;
            r_valid_s3 <= 1'b0;
            r_vop_s3   <= '0;
            r_algo_s3  <= '0;
        end else begin
            // Odd quadrants run the quarter wave backwards.
            r_addr_s1  <= w_quadrant[0] ? ~w_index : w_index;
            r_neg_s1   <= w_quadrant[1];
            r_valid_s1 <= bus.i_Valid;
            r_vop_s1   <= bus.i_VoiceOperator;
            r_algo_s1  <= bus.i_AlgorithmWord;

            r_mag_s2   <= w_lut[r_addr_s1];
            r_neg_s2   <= r_neg_s1;
            r_valid_s2 <= r_valid_s1;
            r_vop_s2   <= r_vop_s1;
            r_algo_s2  <= r_algo_s1;

            r_wave_s3  <= w_wave;
            r_valid_s3 <= r_valid_s2;
            r_vop_s3   <= r_vop_s2;
            r_algo_s3  <= r_algo_s2;
        end
    end

    assign bus.o_Valid         = r_valid_s3;
    assign bus.o_Waveform      = r_wave_s3;
    assign bus.o_VoiceOperator = r_vop_s3;
    assign bus.o_AlgorithmWord = r_algo_s3;

endmodule
`default_nettype wire

// File: tb/tb_stage_waveform_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage_waveform_generator
//  Description : Self-checking bench for stage_waveform_generator. A reference
//                model computes each sample directly from the sine of the
//                quantised phase angle; a scoreboard lines inputs up with
//                outputs three cycles later.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stage_waveform_generator;
    localparam int  c_VOP_BITS  = 8;
    localparam int  c_ALGO_BITS = 16;
    localparam int  c_LATENCY   = 3;
    localparam real c_PI        = 3.14159265358979323846;

    logic clk;
    logic rst;

    stage_waveform_generator_if #(
        .VOICE_OP_BITS  (c_VOP_BITS),
        .ALGORITHM_BITS (c_ALGO_BITS)
    ) bus ();

    stage_waveform_generator #(
        .LUT_ADDR_BITS  (10),
        .VOICE_OP_BITS  (c_VOP_BITS),
        .ALGORITHM_BITS (c_ALGO_BITS)
    ) u_dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] p;
        int          wave;
        int          vop;
        int          algo;
    } exp_t;

    exp_t sb [$];
    int   obs [65536];
    int   n_tests;
    int   n_fail;

    task automatic check_val(input string tag, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Sample = 32767*sin of the centre of the 1/4096-turn bin holding P,
    // rounded half away from zero.
    function automatic int model_wave(input logic [15:0] p);
        logic [11:0] bin;
        real         s;
        bin = p[15:4];
        s   = 32767.0 * $sin(2.0 * c_PI * (real'(bin) + 0.5) / 4096.0);
        if (s >= 0.0) return $rtoi(s + 0.5);
        else          return -$rtoi(-s + 0.5);
    endfunction

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_valid"}, int'(bus.o_Valid), 0);
        check_val({tag, "_wave"},  int'(bus.o_Waveform), 0);
        check_val({tag, "_vop"},   int'(bus.o_VoiceOperator), 0);
        check_val({tag, "_algo"},  int'(bus.o_AlgorithmWord), 0);
    endtask

    // One clock of stimulus; checks the output for the input of three
    // cycles ago once the pipeline holds that many.
    task automatic cycle(input logic v, input logic [15:0] p,
                         input logic [c_VOP_BITS-1:0] vop,
                         input logic [c_ALGO_BITS-1:0] algo);
        exp_t e;
        bus.i_Valid          = v;
        bus.i_ModulatedPhase = p;
        bus.i_VoiceOperator  = vop;
        bus.i_AlgorithmWord  = algo;
        @(posedge clk);
        e.v    = v;
        e.p    = p;
        e.wave = model_wave(p);
        e.vop  = int'(vop);
        e.algo = int'(algo);
        sb.push_back(e);
        #1;
        if (sb.size() == c_LATENCY) begin
            e = sb.pop_front();
            check_val("o_valid", int'(bus.o_Valid), int'(e.v));
            if (e.v) begin
                check_val("o_wave", int'(bus.o_Waveform), e.wave);
                check_val("o_vop",  int'(bus.o_VoiceOperator), e.vop);
                check_val("o_algo", int'(bus.o_AlgorithmWord), e.algo);
                obs[e.p] = int'(bus.o_Waveform);
            end
        end else begin
            check_val("fill_valid", int'(bus.o_Valid), 0);
        end
    endtask

    task automatic flush();
        repeat (c_LATENCY - 1) cycle(1'b0, 16'h0000, '0, '0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 65536; i++) obs[i] = 99999;

        rst                  = 1'b1;
        bus.i_Valid          = 1'b0;
        bus.i_ModulatedPhase = '0;
        bus.i_VoiceOperator  = '0;
        bus.i_AlgorithmWord  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Quadrant points
        begin
            logic [15:0] pts [5];
            pts = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
            for (int i = 0; i < 5; i++) cycle(1'b1, pts[i], 8'(i), 16'(i));
            flush();
        end
        check_val("quad_0000", obs[16'h0000], 25);
        check_val("quad_4000", obs[16'h4000], 32767);
        check_val("quad_8000", obs[16'h8000], -25);
        check_val("quad_C000", obs[16'hC000], -32767);
        check_val("quad_FFFF", obs[16'hFFFF], -25);

        // Low-bit truncation
        for (int i = 0; i < 16; i++) cycle(1'b1, 16'h1230 + 16'(i), 8'hA5, 16'(i));
        flush();
        for (int i = 0; i < 16; i++)
            check_val("trunc", obs[16'h1230 + i], model_wave(16'h1230));

        // Valid bubbles
        begin
            logic pat [5];
            pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 5; i++)
                cycle(pat[i], 16'($urandom), 8'(8'h40 + i), 16'($urandom));
            flush();
        end

        // Sideband alignment: incrementing tag, random word
        for (int i = 0; i < 64; i++)
            cycle(1'b1, 16'($urandom), 8'(i), 16'($urandom));
        flush();

        // Random traffic
        for (int i = 0; i < 3000; i++)
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom),
                  8'($urandom), 16'($urandom));

        // Reset mid-stream with valid input every cycle
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'($urandom), 8'(i), 16'($urandom));
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("held_reset");
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'($urandom), 8'(i), 16'($urandom));
        flush();

        // Full-circle sweep, then symmetry checks on what came out
        for (int p = 0; p < 65536; p++)
            cycle(1'b1, 16'(p), 8'(p), 16'(p));
        flush();
        for (int p = 0; p < 32768; p++) begin
            check_val("mirror", obs[p], obs[32767 - p]);
            check_val("antisym", obs[p + 32768], -obs[p]);
        end
        for (int p = 0; p < 65536; p++) begin
            if (obs[p] > 32767 || obs[p] < -32767)
                check_val("bound", obs[p], 32767);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
